// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, handshakes with instruction memory and presents
// {pc, instr, flush} to the enable-less IF/ID register. Define IF_FETCH_SKID_EN for the one-entry skid buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        out_v;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        xfer;
  logic        full_next;
  logic        req_block;

`ifdef IF_FETCH_SKID_EN
  logic        buf_v;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  assign full_next = buf_v || (xfer && out_v);
  assign req_block = 1'b0;
`else
  // Without a skid entry a stalled, valid output has nowhere to put a new word.
  assign full_next = out_v || xfer;
  assign req_block = out_v && stall_i;
`endif

  assign imem_req_o  = (state == FETCH) && !redirect_i && !rst_i && !req_block;
  assign xfer        = imem_req_o && imem_ack_i;
  assign imem_addr_o = fetch_pc;
  assign pc_o        = out_v ? out_pc : 32'd0;
  assign instr_o     = out_v ? out_instr : 32'd0;
  assign flush_o     = rst_i || redirect_i || !out_v;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= BOOT;
      fetch_pc  <= RESET_PC;
      out_v     <= 1'b0;
      out_pc    <= 32'd0;
      out_instr <= 32'd0;
`ifdef IF_FETCH_SKID_EN
      buf_v     <= 1'b0;
      buf_pc    <= 32'd0;
      buf_instr <= 32'd0;
`endif
    end else if (redirect_i) begin
      state    <= FETCH;
      fetch_pc <= redirect_pc_i & ~32'h3;
      out_v    <= 1'b0;
`ifdef IF_FETCH_SKID_EN
      buf_v    <= 1'b0;
`endif
    end else begin
      if (xfer) fetch_pc <= fetch_pc + 32'd4;

      if (!stall_i) begin
`ifdef IF_FETCH_SKID_EN
        // The skid entry is older than anything arriving now, so it drains first.
        if (buf_v) begin
          out_v     <= 1'b1;
          out_pc    <= buf_pc;
          out_instr <= buf_instr;
          buf_v     <= xfer;
          if (xfer) begin
            buf_pc    <= fetch_pc;
            buf_instr <= imem_data_i;
          end
        end else
`endif
        if (xfer) begin
          out_v     <= 1'b1;
          out_pc    <= fetch_pc;
          out_instr <= imem_data_i;
        end else begin
          out_v <= 1'b0;
        end
      end else if (xfer) begin
        if (!out_v) begin
          out_v     <= 1'b1;
          out_pc    <= fetch_pc;
          out_instr <= imem_data_i;
        end
`ifdef IF_FETCH_SKID_EN
        else begin
          buf_v     <= 1'b1;
          buf_pc    <= fetch_pc;
          buf_instr <= imem_data_i;
        end
`endif
      end

      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (stall_i && full_next) state <= FULL;
        FULL:    if (!stall_i) state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a queue of expected fetch PCs is drained whenever IF/ID
// consumes a valid instruction, alongside cycle-exact checks of handshake and flush behaviour.
module tb_if_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        flush_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .pc_o         (pc_o),
    .instr_o      (instr_o),
    .flush_o      (flush_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5000;
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then score any instruction IF/ID consumes.
  task automatic applyStimulus(input logic rst, input logic stall, input logic redir,
                               input logic [31:0] rpc, input logic ack);
    logic [31:0] exp_pc;
    @(negedge clk_i);
    rst_i         = rst;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_ack_i    = ack;
    #1;
    if (!rst && !stall && !redir && !flush_o) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_instr_queue_size", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_pc = sb_q.pop_front();
        checkOutput("sb_pc", pc_o, exp_pc);
        checkOutput("sb_instr", instr_o, mem_word(exp_pc));
      end
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic pushSeq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(first + 32'(4 * i));
  endtask

  task automatic endPhase(input string tag);
    checkOutput(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    // Zero-wait memory straight out of reset.
    pushSeq(32'd0, 6);
    for (int k = -2; k < 8; k++) begin
      applyStimulus(k < 0, 1'b0, 1'b0, 32'd0, 1'b1);
      case (k)
        -1: checkOutput("p1_flush_in_reset", 32'(flush_o), 32'd1);
        0: begin
          checkOutput("p1_boot_req", 32'(imem_req_o), 32'd0);
          checkOutput("p1_boot_addr", imem_addr_o, 32'd0);
          checkOutput("p1_boot_pc", pc_o, 32'd0);
          checkOutput("p1_boot_instr", instr_o, 32'd0);
          checkOutput("p1_boot_flush", 32'(flush_o), 32'd1);
        end
        1: begin
          checkOutput("p1_first_req", 32'(imem_req_o), 32'd1);
          checkOutput("p1_first_addr", imem_addr_o, 32'd0);
          checkOutput("p1_first_flush", 32'(flush_o), 32'd1);
        end
        2: begin
          checkOutput("p1_addr4", imem_addr_o, 32'd4);
          checkOutput("p1_valid_flush", 32'(flush_o), 32'd0);
        end
        3: checkOutput("p1_addr8", imem_addr_o, 32'd8);
        default: ;
      endcase
    end
    endPhase("p1_drain");

    // Two wait states per fetch.
    resetDut();
    pushSeq(32'd0, 3);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, (k % 3) == 0);
      case (k)
        1: begin
          checkOutput("p2_req", 32'(imem_req_o), 32'd1);
          checkOutput("p2_addr_w1", imem_addr_o, 32'd0);
        end
        2: checkOutput("p2_addr_w2", imem_addr_o, 32'd0);
        4: checkOutput("p2_flush_valid", 32'(flush_o), 32'd0);
        5: begin
          checkOutput("p2_flush_empty", 32'(flush_o), 32'd1);
          checkOutput("p2_addr_next", imem_addr_o, 32'd4);
        end
        6: checkOutput("p2_addr_hold", imem_addr_o, 32'd4);
        7: checkOutput("p2_addr_8", imem_addr_o, 32'd8);
        default: ;
      endcase
    end
    endPhase("p2_drain");

    // Three-cycle decode stall while pc 8 is presented.
    resetDut();
`ifdef IF_FETCH_SKID_EN
    pushSeq(32'd0, 6);
`else
    pushSeq(32'd0, 5);
`endif
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, (k >= 4) && (k <= 6), 1'b0, 32'd0, 1'b1);
      if (k >= 4 && k <= 6) begin
        checkOutput("p3_hold_pc", pc_o, 32'd8);
        checkOutput("p3_hold_instr", instr_o, mem_word(32'd8));
      end
      if (k == 5 || k == 6) checkOutput("p3_req_dropped", 32'(imem_req_o), 32'd0);
`ifdef IF_FETCH_SKID_EN
      if (k == 4) checkOutput("p3_skid_req", 32'(imem_req_o), 32'd1);
      if (k == 5 || k == 6) checkOutput("p3_skid_addr", imem_addr_o, 32'd16);
      if (k == 8) begin
        checkOutput("p3_skid_pc", pc_o, 32'd12);
        checkOutput("p3_skid_noflush", 32'(flush_o), 32'd0);
      end
`else
      if (k == 5 || k == 6) checkOutput("p3_addr_hold", imem_addr_o, 32'd12);
      if (k == 8) begin
        checkOutput("p3_bubble", 32'(flush_o), 32'd1);
        checkOutput("p3_refetch_addr", imem_addr_o, 32'd12);
      end
`endif
    end
    endPhase("p3_drain");

    // Redirect during a stall with the memory acking.
    resetDut();
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd4);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b0, (k == 4) || (k == 5), k == 5, 32'h0000_0103, 1'b1);
      case (k)
        5: begin
          checkOutput("p4_redir_flush", 32'(flush_o), 32'd1);
          checkOutput("p4_redir_req", 32'(imem_req_o), 32'd0);
        end
        6: begin
          checkOutput("p4_target_addr", imem_addr_o, 32'h100);
          checkOutput("p4_out_cleared", pc_o, 32'd0);
          checkOutput("p4_bubble", 32'(flush_o), 32'd1);
        end
        7: checkOutput("p4_target_pc", pc_o, 32'h100);
        default: ;
      endcase
    end
    endPhase("p4_drain");

    // Redirect from a running fetch to the last word, then wrap.
    resetDut();
    sb_q.push_back(32'd0);
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'd0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 1'b0, k == 3, 32'hFFFF_FFFC, 1'b1);
      case (k)
        3: begin
          checkOutput("p5_redir_req", 32'(imem_req_o), 32'd0);
          checkOutput("p5_redir_flush", 32'(flush_o), 32'd1);
        end
        4: begin
          checkOutput("p5_top_addr", imem_addr_o, 32'hFFFF_FFFC);
          checkOutput("p5_one_bubble", 32'(flush_o), 32'd1);
        end
        5: begin
          checkOutput("p5_wrap_addr", imem_addr_o, 32'd0);
          checkOutput("p5_after_bubble", 32'(flush_o), 32'd0);
        end
        6: checkOutput("p5_addr4", imem_addr_o, 32'd4);
        default: ;
      endcase
    end
    endPhase("p5_drain");

    // Reset arriving in the middle of a stall, skid full when present.
    resetDut();
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd4);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd4);
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 6) || (k == 7), (k >= 4) && (k <= 7), 1'b0, 32'd0, 1'b1);
      case (k)
        6: checkOutput("p6_flush_in_reset", 32'(flush_o), 32'd1);
        8: begin
          checkOutput("p6_boot_flush", 32'(flush_o), 32'd1);
          checkOutput("p6_boot_pc", pc_o, 32'd0);
          checkOutput("p6_boot_req", 32'(imem_req_o), 32'd0);
          checkOutput("p6_boot_addr", imem_addr_o, 32'd0);
        end
        9: checkOutput("p6_restart_addr", imem_addr_o, 32'd0);
        default: ;
      endcase
    end
    endPhase("p6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
